// File: rtl/imem_boot_arbiter.sv
// imem_boot_arbiter: boot loader plus fetch/debug sharing of the instruction memory port
module imem_boot_arbiter #(
  parameter int          DEPTH    = 101,
  parameter logic [21:0] NOP_WORD = 22'h000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [21:0] pc_i,
  output logic [21:0] instr_o,
  output logic        fetch_stall_o,
  output logic        cpu_run_o,
  output logic        fault_o,
  input  logic        ld_valid_i,
  input  logic [21:0] ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_ready_o,
  input  logic        reload_i,
  input  logic        dbg_req_i,
  input  logic [21:0] dbg_addr_i,
  output logic        dbg_ack_o,
  output logic [21:0] dbg_data_o,
  output logic [21:0] mem_a_o,
  output logic        mem_we_o,
  output logic [21:0] mem_wd_o,
  input  logic [21:0] mem_rd_i
);
  localparam int AW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {LOAD, RUN, DBG} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, prog_len_q, prog_len_d;
  logic          fault_q, fault_d, dbg_ack_q, dbg_ack_d;
  logic [21:0]   dbg_data_q, dbg_data_d;
  logic          in_range;
  // full 20-bit word index against the loaded length, no wrap
  assign in_range = pc_i[21:2] < {{(20-AW){1'b0}}, prog_len_q};
  assign fault_o    = fault_q;
  assign dbg_ack_o  = dbg_ack_q;
  assign dbg_data_o = dbg_data_q;
  // next-state and port muxing; ld_ready is gated by reset so nothing is written while held in reset
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    fault_d       = fault_q;
    dbg_ack_d     = 1'b0;
    dbg_data_d    = dbg_data_q;
    ld_ready_o    = 1'b0;
    cpu_run_o     = 1'b0;
    fetch_stall_o = 1'b1;
    instr_o       = NOP_WORD;
    mem_a_o       = pc_i;
    mem_we_o      = 1'b0;
    mem_wd_o      = ld_data_i;
    unique case (state_q)
      LOAD: begin
        ld_ready_o = rst_ni;
        if (ld_valid_i && rst_ni) begin
          mem_we_o = 1'b1;
          mem_a_o  = {{(20-AW){1'b0}}, wr_ptr_q, 2'b00};
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (ld_last_i || wr_ptr_q == AW'(DEPTH - 1)) begin
            prog_len_d = wr_ptr_q + 1'b1;
            wr_ptr_d   = '0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        cpu_run_o     = 1'b1;
        fetch_stall_o = 1'b0;
        instr_o       = in_range ? mem_rd_i : NOP_WORD;
        fault_d       = fault_q | ~in_range;
        if (reload_i) begin
          state_d       = LOAD;
          wr_ptr_d      = '0;
          fault_d       = 1'b0;
          fetch_stall_o = 1'b1;
        end else if (dbg_req_i && !dbg_ack_q) begin
          state_d       = DBG;
          fetch_stall_o = 1'b1;
        end
      end
      DBG: begin
        cpu_run_o  = 1'b1;
        mem_a_o    = dbg_addr_i;
        dbg_data_d = mem_rd_i;
        dbg_ack_d  = 1'b1;
        state_d    = RUN;
      end
      default: state_d = LOAD;
    endcase
  end
  // state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      fault_q    <= 1'b0;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      fault_q    <= fault_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
    end
  end
endmodule

// File: tb/tb_imem_boot_arbiter.sv
// tb_imem_boot_arbiter: randomized self-checking bench against a behavioural model
module tb_imem_boot_arbiter;
  localparam int          DEPTH = 101;
  localparam logic [21:0] NOP   = 22'h000000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [21:0] pc = '0, ld_data = '0, dbg_addr = '0;
  logic        ld_valid = 1'b0, ld_last = 1'b0, reload = 1'b0, dbg_req = 1'b0;
  logic [21:0] instr, dbg_data, mem_a, mem_wd, mem_rd;
  logic        fetch_stall, cpu_run, fault, ld_ready, dbg_ack, mem_we;
  logic [21:0] mem [DEPTH];
  int          wr_cnt = 0;
  logic [21:0] exp_mem [DEPTH];
  int          exp_len = 0, m_wp = 0, n_chk = 0, n_fail = 0;
  bit          m_load = 1'b1, m_fault = 1'b0;
  imem_boot_arbiter #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_i(pc), .instr_o(instr), .fetch_stall_o(fetch_stall),
    .cpu_run_o(cpu_run), .fault_o(fault), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_last_i(ld_last), .ld_ready_o(ld_ready), .reload_i(reload), .dbg_req_i(dbg_req),
    .dbg_addr_i(dbg_addr), .dbg_ack_o(dbg_ack), .dbg_data_o(dbg_data), .mem_a_o(mem_a),
    .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );
  always #5 clk = ~clk;
  assign mem_rd = (int'(mem_a[21:2]) < DEPTH) ? mem[int'(mem_a[21:2])] : '0;
  always @(posedge clk) if (mem_we && int'(mem_a[21:2]) < DEPTH) begin
    mem[int'(mem_a[21:2])] <= mem_wd;
    wr_cnt <= wr_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load(input int n, input bit last, input bit use_w0);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = (use_w0 && i == 0) ? 22'h268088 : 22'($urandom);
      ld_last  = last && i == n - 1;
      #1 check("ld_ready", ld_ready, m_load);
      check("mem_we", mem_we, m_load);
      if (m_load) begin
        exp_mem[m_wp] = ld_data;
        m_wp++;
        if (ld_last || m_wp == DEPTH) begin
          exp_len = m_wp;
          m_wp    = 0;
          m_load  = 1'b0;
        end
      end
      cyc();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask
  task automatic fetch(input logic [21:0] p);
    int idx;
    bit inr;
    pc  = p;
    idx = int'(p[21:2]);
    inr = idx < exp_len;
    #1 check("instr", instr, inr ? exp_mem[idx] : NOP);
    check("fetch_stall", fetch_stall, 0);
    check("cpu_run", cpu_run, 1);
    check("fault", fault, m_fault);
    cyc();
    if (!inr) m_fault = 1'b1;
  endtask
  task automatic reload_req(input bit with_dbg);
    reload  = 1'b1;
    dbg_req = with_dbg;
    #1 check("reload_stall", fetch_stall, 1);
    cyc();
    reload  = 1'b0;
    dbg_req = 1'b0;
    m_load  = 1'b1;
    m_wp    = 0;
    m_fault = 1'b0;
    #1 check("reload_cpu_run", cpu_run, 0);
    check("reload_ld_ready", ld_ready, 1);
    check("reload_fault", fault, 0);
    check("reload_instr", instr, NOP);
    cyc();
    #1 check("reload_no_ack", dbg_ack, 0);
    check("reload_still_load", cpu_run, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [21:0] a;
    int          base;
    #1 check("rst_stall", fetch_stall, 1);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_instr", instr, NOP);
    check("rst_mem_we", mem_we, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_dbg_data", dbg_data, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_ld_ready", ld_ready, 1);
    @(negedge clk);
    load(9, 1'b1, 1'b1);
    #1 check("boot_writes", wr_cnt, 9);
    check("boot_cpu_run", cpu_run, 1);
    check("boot_stall", fetch_stall, 0);
    check("boot_ld_ready", ld_ready, 0);
    for (int i = 0; i < 9; i++) check("boot_mem", mem[i], exp_mem[i]);
    fetch(22'h20);
    fetch(22'h24);
    fetch(22'h0);
    for (int i = 0; i < 20; i++) fetch(22'($urandom_range(0, (exp_len + 3) * 4 - 1)));
    reload_req(1'b1);
    load(3, 1'b1, 1'b0);
    fetch(22'h8);
    fetch(22'hC);
    reload_req(1'b0);
    base = wr_cnt;
    load(105, 1'b0, 1'b0);
    check("ovf_writes", wr_cnt - base, DEPTH);
    fetch(22'(100 * 4));
    fetch(22'(101 * 4));
    fetch(22'h0);
    pc = '0;
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 0) a = (k == 0) ? (22'h8 | 22'($urandom_range(0, 3))) : 22'($urandom_range(0, DEPTH * 4 - 1));
      dbg_req  = 1'b1;
      dbg_addr = a;
      #1 check("dbg_cpu_run", cpu_run, 1);
      check("dbg_ack", dbg_ack, k % 3 == 2);
      check("dbg_stall", fetch_stall, k % 3 != 2);
      check("dbg_instr", instr, k % 3 == 1 ? NOP : exp_mem[0]);
      if (k % 3 == 2) check("dbg_data", dbg_data, exp_mem[int'(a[21:2])]);
      cyc();
    end
    dbg_req  = 1'b1;
    dbg_addr = 22'($urandom_range(0, DEPTH * 4 - 1));
    a        = dbg_addr;
    #1 check("lost_leave", fetch_stall, 1);
    cyc();
    reload = 1'b1;
    #1 check("lost_dbg_instr", instr, NOP);
    cyc();
    reload  = 1'b0;
    dbg_req = 1'b0;
    #1 check("lost_ack", dbg_ack, 1);
    check("lost_data", dbg_data, exp_mem[int'(a[21:2])]);
    check("lost_stall", fetch_stall, 0);
    cyc();
    #1 check("lost_cpu_run", cpu_run, 1);
    check("lost_ld_ready", ld_ready, 0);
    reload_req(1'b0);
    load(4, 1'b0, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 22'($urandom);
    #2 rst_n = 1'b0;
    #1 check("arst_mem_we", mem_we, 0);
    check("arst_ld_ready", ld_ready, 0);
    check("arst_stall", fetch_stall, 1);
    check("arst_cpu_run", cpu_run, 0);
    check("arst_instr", instr, NOP);
    check("arst_dbg_data", dbg_data, 0);
    check("arst_fault", fault, 0);
    ld_valid = 1'b0;
    m_load   = 1'b1;
    m_wp     = 0;
    exp_len  = 0;
    m_fault  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_rel_ld_ready", ld_ready, 1);
    @(negedge clk);
    load(2, 1'b1, 1'b0);
    fetch(22'h4);
    fetch(22'h8);
    fetch(22'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_boot_arbiter.md
Name: imem_boot_arbiter

Overview:
- Owns the single read/write port of the 22-bit instruction memory.
- After reset it runs a boot loader that streams a program into memory over a valid/ready channel while holding the core stalled.
- It then shares the read port between the pipeline fetch stage (default owner) and a single-cycle debug read port.
- Sits between the fetch stage, the program loader and the instruction memory.

Parameters:
- DEPTH, 101, number of 22-bit words in instruction memory (word index 0..DEPTH-1).
- NOP_WORD, 22'h000000, bubble instruction driven to fetch while it is stalled or out of range.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low
- pc  in  22  fetch byte address; word index = pc[21:2]
- instr  out  22  instruction to fetch stage
- fetch_stall  out  1  fetch must hold pc
- cpu_run  out  1  core may execute
- fault  out  1  sticky: fetch beyond loaded program
- ld_valid  in  1  loader word valid
- ld_data  in  22  loader word
- ld_last  in  1  final word of program
- ld_ready  out  1  loader beat accepted this cycle
- reload  in  1  one-cycle request to re-enter boot load
- dbg_req  in  1  debug read request, held until dbg_ack
- dbg_addr  in  22  debug byte address
- dbg_ack  out  1  one-cycle acknowledge, dbg_data valid
- dbg_data  out  22  debug read data
- mem_a  out  22  memory byte address
- mem_we  out  1  memory write enable (write on clk rising edge)
- mem_wd  out  22  memory write data
- mem_rd  in  22  memory combinational read data

Behaviour:
- Reset (asynchronous on rst low):
  - state=LOAD, wr_ptr=0, prog_len=0, fault=0, cpu_run=0.
  - dbg_ack=0, dbg_data=0.
  - fetch_stall=1, instr=NOP_WORD, mem_we=0.
- Reset mid-load discards the partial program; prog_len stays 0 until a load completes.
- States: LOAD, RUN, DBG. mem_a defaults to pc.
- LOAD:
  - ld_ready=1, cpu_run=0, fetch_stall=1, instr=NOP_WORD.
  - Beat = ld_valid&ld_ready. On a beat: mem_we=1, mem_a={wr_ptr,2'b00}, mem_wd=ld_data; wr_ptr increments.
  - On a beat with ld_last=1 or wr_ptr==DEPTH-1: prog_len<=wr_ptr+1, wr_ptr<=0, next state RUN.
  - Words beyond DEPTH are never written.
  - dbg_req and reload are ignored in LOAD.
- RUN:
  - cpu_run=1, ld_ready=0, mem_we=0, mem_a=pc.
  - fetch_stall=0, except fetch_stall=1 in the cycle the state leaves RUN.
  - instr=mem_rd if pc[21:2]<prog_len; else instr=NOP_WORD and fault<=1 (sticky until reset or reload).
  - Transition priority: reload (go LOAD; wr_ptr=0, fault<=0, cpu_run drops next cycle) > dbg_req (go DBG).
  - dbg_req is not taken in a cycle where dbg_ack=1. This guarantees at least one fetch cycle between debug reads.
- DBG (always one cycle):
  - mem_a=dbg_addr, fetch_stall=1, instr=NOP_WORD, cpu_run=1.
  - dbg_data<=mem_rd (no range check). Next state RUN with dbg_ack=1 for exactly that one cycle.
  - A reload asserted in DBG is taken in the following RUN cycle, so the requester must hold it. reload is a pulse elsewhere, but in DBG the single-cycle pulse is lost by design; the bench must verify this.
- Latency:
  - Fetch: 0 cycles (combinational) in RUN.
  - Debug: dbg_req seen in RUN → DBG next cycle → dbg_ack the cycle after. Minimum 2 cycles.
- Arithmetic:
  - wr_ptr and prog_len are 7 bits (ceil log2(DEPTH+1)).
  - The comparison uses the full 20-bit pc[21:2] zero-extended; no wrap.
  - pc[1:0] and dbg_addr[1:0] are ignored.
- Simultaneous events:
  - ld_last on the DEPTH-1 beat: single transition, prog_len=DEPTH.
  - ld_valid in RUN: ignored, ld_ready=0.

Test Plan:
- Boot: reset, stream 9 words 22'h268088…, ld_last on 9th → ld_ready high 9 beats; memory words 0..8 written in order; prog_len=9; RUN entered the cycle after; cpu_run=1, fetch_stall=0.
- Fetch/range: pc=0x20 → instr=word 8; pc=0x24 → instr=NOP_WORD, fault=1, stays 1 for pc=0x0.
- Overflow: stream 105 words without ld_last → only 101 writes; state RUN after beat 101; prog_len=101; beats 102-105 see ld_ready=0.
- Debug: in RUN, dbg_req=1, dbg_addr=0x8 held → DBG one cycle with fetch_stall=1, instr=NOP_WORD; next cycle dbg_ack=1, dbg_data=word 2; back-to-back held request gets at least one fetch cycle between acks.
- Reload priority: in RUN, reload=1 and dbg_req=1 same cycle → LOAD next cycle; no dbg_ack; fault cleared; cpu_run=0; new 3-word load sets prog_len=3.
- Async reset mid-load: rst low after 4 beats → all outputs to reset values immediately (fetch_stall=1, cpu_run=0, ld_ready=1 after release); reload of 2 words gives prog_len=2.
